// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-lane RAM plus an I/O page with a cycle counter
// and a buffered byte console. The console is built only when DMEM_CONSOLE_EN is defined.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  cons_data,
  output logic        cons_valid,
  input  logic        cons_ready
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          is_io;
  logic [1:0]    io_sel;
  logic [31:0]   cycle_count;
  logic [31:0]   stat_word;
  logic          unused_sink;

  assign word_idx = daddr[AW+1:2];
  assign is_io    = daddr[31];
  assign io_sel   = daddr[3:2];

  // Upper address bits alias the RAM; the byte offset is ignored.
  assign unused_sink = ^{daddr[30:AW+2], daddr[1:0], cons_ready};

  always_ff @(posedge clk) begin
    if (!is_io) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) mem[word_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_count <= '0;
    else       cycle_count <= cycle_count + 32'd1;
  end

`ifdef DMEM_CONSOLE_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic          full, empty, push_req, pop, push_ok, ovf_clr;
  logic [31:0]   count_ext;
  logic [3:0]    count_disp;

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push_req  = is_io && (io_sel == 2'd1) && dwe[0];
  assign pop       = !empty && cons_ready;
  // A pop frees a slot in the same edge, so a full FIFO still takes the push.
  assign push_ok   = push_req && (!full || pop);
  assign ovf_clr   = is_io && (io_sel == 2'd2) && (|dwe) && dwdata[2];
  assign count_ext = 32'(count);
  assign count_disp = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= dwdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  assign stat_word  = {24'd0, count_disp, 1'b0, overflow, empty, full};
  assign cons_valid = !empty;
  assign cons_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
`else
  assign stat_word  = 32'd0;
  assign cons_valid = 1'b0;
  assign cons_data  = 8'h00;
`endif

  always_comb begin
    drdata = 32'd0;
    if (!is_io) begin
      drdata = mem[word_idx];
    end else begin
      case (io_sel)
        2'd0:    drdata = cycle_count;
        2'd2:    drdata = stat_word;
        default: drdata = 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random traffic against a
// byte-level RAM model, a time-based cycle model and a queue console model.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int FD    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dwe = '0;
  logic [31:0] drdata;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [DEPTH];
  logic [3:0]  known [DEPTH];
  logic [7:0]  q [$];
  logic        ovf = 1'b0;
  time         t_rel = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .cons_data(cons_data), .cons_valid(cons_valid),
    .cons_ready(cons_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  function automatic logic [31:0] exp_stat();
`ifdef DMEM_CONSOLE_EN
    int n = q.size();
    return {24'd0, 4'(n > 15 ? 15 : n), 1'b0, ovf, n == 0, n == FD};
`else
    return 32'd0;
`endif
  endfunction

  // One bus cycle: drive, check the combinational read and console outputs, then update models.
  task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                    input logic rdy);
    logic [31:0] exp, mask;
    logic [7:0]  hd;
    int          idx;
    @(negedge clk);
    daddr = a; dwdata = wd; dwe = we; cons_ready = rdy;
    #1;
    idx = int'((a >> 2) % DEPTH);
    if (!a[31]) begin
      mask = lane_mask(known[idx]);
      exp  = ram_m[idx];
    end else begin
      mask = '1;
      case (a[3:2])
        2'd0:    exp = 32'(($time - t_rel) / 10);
        2'd2:    exp = exp_stat();
        default: exp = 32'd0;
      endcase
    end
    chk("drdata", drdata & mask, exp & mask);
    hd = (q.size() != 0) ? q[0] : 8'h00;
    chk("cons_valid", 32'(cons_valid), 32'(q.size() != 0));
    chk("cons_data", 32'(cons_data), 32'(hd));
    if (!a[31]) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          ram_m[idx][8*i +: 8] = wd[8*i +: 8];
          known[idx][i] = 1'b1;
        end
      end
    end
`ifdef DMEM_CONSOLE_EN
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (a[31] && a[3:2] == 2'd1 && we[0]) begin
      if (q.size() < FD) q.push_back(wd[7:0]);
      else ovf = 1'b1;
    end
    if (a[31] && a[3:2] == 2'd2 && (|we) && wd[2]) ovf = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; dwe = '0; cons_ready = 1'b0;
    @(posedge clk);
    t_rel = $time;
    q.delete();
    ovf = 1'b0;
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) known[i] = 4'h0;
    do_reset();

    // Counter reads in cycles 0 and 5 after release.
    op(32'h8000_0000, 0, 4'h0, 1'b0);
    chk("cycle0", drdata, 32'd0);
    for (int i = 0; i < 4; i++) op(32'h0000_0100, 0, 4'h0, 1'b0);
    op(32'h8000_0000, 0, 4'h0, 1'b0);
    chk("cycle5", drdata, 32'd5);

    // Byte-lane write and aliasing.
    op(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    op(32'h0000_0010, 32'h00AA_0000, 4'b0100, 1'b0);
    op(32'h0000_0010, 0, 4'h0, 1'b0);
    chk("ram_lane", drdata, 32'hDEAA_BEEF);
    op(32'h0000_0010 + 4 * DEPTH, 0, 4'h0, 1'b0);
    chk("ram_alias", drdata, 32'hDEAA_BEEF);

    // Counter wrap via a forced preload.
    @(negedge clk);
    daddr = 32'h8000_0000; dwe = '0;
    force dut.cycle_count = 32'hFFFF_FFFF;
    #1 chk("cycle_forced", drdata, 32'hFFFF_FFFF);
    @(negedge clk);
    release dut.cycle_count;
    #1 chk("cycle_hold", drdata, 32'hFFFF_FFFF);
    @(negedge clk);
    #1 chk("cycle_wrap", drdata, 32'h0000_0000);
    do_reset();

`ifdef DMEM_CONSOLE_EN
    for (int b = 8'h41; b <= 8'h48; b++) op(32'h8000_0004, 32'(b), 4'h1, 1'b0);
    op(32'h8000_0008, 0, 4'h0, 1'b0);
    chk("stat_full", drdata, 32'h81);
    op(32'h8000_0004, 32'h49, 4'h1, 1'b0);
    op(32'h8000_0008, 0, 4'h0, 1'b0);
    chk("stat_ovf", drdata, 32'h85);
    op(32'h8000_0008, 32'h0, 4'hF, 1'b0);
    op(32'h8000_0008, 0, 4'h0, 1'b0);
    chk("stat_ovf_kept", drdata, 32'h85);
    op(32'h8000_0008, 32'h4, 4'hF, 1'b0);
    op(32'h8000_0008, 0, 4'h0, 1'b0);
    chk("stat_ovf_clr", drdata, 32'h81);
    op(32'h8000_0004, 32'h50, 4'h1, 1'b1);
    op(32'h8000_0008, 0, 4'h0, 1'b0);
    chk("stat_push_pop_full", drdata, 32'h81);
    for (int i = 0; i < 10; i++) op(32'h0000_0200, 0, 4'h0, 1'b1);
    chk("drained_valid", 32'(cons_valid), 32'd0);
    for (int b = 1; b <= 3; b++) op(32'h8000_0004, 32'(b), 4'h1, 1'b0);
    do_reset();
    op(32'h8000_0000, 0, 4'h0, 1'b0);
    chk("reset_cycle", drdata, 32'd0);
    chk("reset_valid", 32'(cons_valid), 32'd0);
    op(32'h8000_0008, 0, 4'h0, 1'b0);
    chk("reset_stat", drdata, 32'h2);
`else
    op(32'h8000_0004, 32'hFF, 4'hF, 1'b1);
    op(32'h8000_0008, 32'h4, 4'hF, 1'b0);
    op(32'h8000_0008, 0, 4'h0, 1'b0);
    chk("off_stat", drdata, 32'd0);
    chk("off_valid", 32'(cons_valid), 32'd0);
    chk("off_data", 32'(cons_data), 32'd0);
`endif

    // Random traffic over RAM and the I/O page.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        a = 32'($urandom_range(0, 7)) * 32'(4 * DEPTH) + 32'($urandom_range(0, 15)) * 4
            + 32'($urandom_range(0, 3));
      end else begin
        a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF3) | (32'($urandom_range(0, 3)) << 2);
      end
      op(a, $urandom, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
